// File: rtl/cbus_arbiter.sv
// cbus_arbiter: merges N cache-side cbus masters onto one memory-side cbus.
// A grant covers a whole burst; responses are routed only to the owning master.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

// Handshake: a master holds ireqs[i].valid (and its request fields) until its
// burst is finished; a beat completes in any cycle with oresp.ready=1, and the
// burst ends on the beat where oresp.ready=1 and oresp.last=1.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int N          = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  cbus_req_t              ireqs  [N],
  output cbus_resp_t             iresps [N],
  output cbus_req_t              oreq,
  input  cbus_resp_t             oresp,
  output logic                   busy,
  output logic [$clog2(N)-1:0]   index
);

  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [IW-1:0] last_grant, last_grant_next, index_next, winner;
  logic [N-1:0]  valids;
  int            cand;

  always_comb begin
    valids = '0;
    for (int i = 0; i < N; i++) valids[i] = ireqs[i].valid;
  end

  // Scan from farthest to nearest so the first valid after last_grant wins.
  always_comb begin
    winner = '0;
    cand   = 0;
    if (FIXED_PRIO != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (valids[i]) winner = IW'(i);
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        cand = (int'(last_grant) + k) % N;
        if (valids[cand[IW-1:0]]) winner = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state      <= IDLE;
      index      <= '0;
      last_grant <= IW'(N - 1);
    end else begin
      state      <= state_next;
      index      <= index_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    index_next      = index;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (|valids) begin
          state_next      = BUSY;
          index_next      = winner;
          last_grant_next = winner;
        end
      end
      BUSY: begin
        if (oresp.ready && oresp.last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == BUSY);

  // Outputs depend only on registered state plus live pass-through data, so
  // there is no combinational path from oresp to oreq.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < N; i++) iresps[i] = '0;
    if (busy) begin
      for (int i = 0; i < N; i++) begin
        if (IW'(i) == index) begin
          oreq       = ireqs[i];
          oreq.valid = 1'b1;
          iresps[i]  = oresp;
        end
      end
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: a round-robin and a fixed-priority instance driven by
// random masters and a random memory, checked cycle by cycle against a model.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 3;
  localparam int D = 2;

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  cbus_req_t  req     [D][N];
  cbus_req_t  nreq    [D][N];
  cbus_resp_t iresp   [D][N];
  cbus_req_t  oreq    [D];
  cbus_resp_t oresp   [D];
  logic       busy_o  [D];
  logic [1:0] index_o [D];

  cbus_req_t  req0 [N], req1 [N];
  cbus_resp_t ir0  [N], ir1  [N];

  for (genvar i = 0; i < N; i++) begin : g_conn
    assign req0[i]     = req[0][i];
    assign req1[i]     = req[1][i];
    assign iresp[0][i] = ir0[i];
    assign iresp[1][i] = ir1[i];
  end

  cbus_arbiter #(.N(N), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset_(reset_), .ireqs(req0), .iresps(ir0),
    .oreq(oreq[0]), .oresp(oresp[0]), .busy(busy_o[0]), .index(index_o[0])
  );

  cbus_arbiter #(.N(N), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset_(reset_), .ireqs(req1), .iresps(ir1),
    .oreq(oreq[1]), .oresp(oresp[1]), .busy(busy_o[1]), .index(index_o[1])
  );

  // Reference model: owner = -1 while idle, ptr = last granted port.
  int owner [D];
  int ptr   [D];
  int beats [D];
  int g_cnt [D][N];
  logic prev_busy [D];
  logic [1:0] exp_q0 [$];
  logic [1:0] exp_q1 [$];

  int rdy_pct, new_pct, rereq_pct;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cbus_req_t new_req();
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = 1'($urandom_range(1));
    r.size     = 3'($urandom_range(3));
    r.addr     = $urandom;
    r.strobe   = 8'($urandom);
    r.data     = {$urandom, $urandom};
    r.len      = 8'($urandom_range(3));
    r.burst    = 2'($urandom_range(2));
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < D; d++) begin
      owner[d]     = -1;
      ptr[d]       = N - 1;
      beats[d]     = 0;
      prev_busy[d] = 1'b0;
      for (int m = 0; m < N; m++) nreq[d][m] = '0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic drive_mem(input int d);
    cbus_resp_t r;
    r.data  = {$urandom, $urandom};
    r.ready = ($urandom_range(99) < rdy_pct);
    if (owner[d] >= 0 && beats[d] == 1) r.last = 1'b1;
    else if (r.ready && owner[d] >= 0)  r.last = 1'b0;
    else                                r.last = 1'($urandom_range(1));
    oresp[d] = r;
  endtask

  task automatic check_outputs(input int d);
    cbus_req_t  e;
    cbus_resp_t er;
    e = '0;
    if (owner[d] >= 0) begin
      e       = req[d][owner[d]];
      e.valid = 1'b1;
    end
    check($sformatf("oreq[%0d]", d), 128'(oreq[d]), 128'(e));
    for (int m = 0; m < N; m++) begin
      er = (owner[d] == m) ? oresp[d] : '0;
      check($sformatf("iresps[%0d][%0d]", d, m), 128'(iresp[d][m]), 128'(er));
    end
    check($sformatf("busy[%0d]", d), 128'(busy_o[d]), 128'(owner[d] >= 0));
    if (busy_o[d] && !prev_busy[d]) begin
      int qs;
      logic [1:0] eg;
      qs = (d == 0) ? exp_q0.size() : exp_q1.size();
      check($sformatf("grant_pending[%0d]", d), 128'(qs > 0), 128'(1));
      if (qs > 0) begin
        if (d == 0) eg = exp_q0.pop_front();
        else        eg = exp_q1.pop_front();
        check($sformatf("grant_index[%0d]", d), 128'(index_o[d]), 128'(eg));
        g_cnt[d][index_o[d]]++;
      end
    end
    prev_busy[d] = busy_o[d];
  endtask

  task automatic advance(input int d);
    int w, fin, c;
    fin = -1;
    for (int m = 0; m < N; m++) nreq[d][m] = req[d][m];
    if (!reset_) begin
      owner[d] = -1;
      ptr[d]   = N - 1;
      for (int m = 0; m < N; m++) nreq[d][m] = '0;
    end else begin
      if (owner[d] >= 0) begin
        if (oresp[d].ready) begin
          if (oresp[d].last) begin
            fin      = owner[d];
            owner[d] = -1;
            if ($urandom_range(99) < rereq_pct) nreq[d][fin] = new_req();
            else                                nreq[d][fin] = '0;
          end else begin
            beats[d]--;
            nreq[d][owner[d]].data = {$urandom, $urandom};
          end
        end
      end else begin
        w = -1;
        if (d == 1) begin
          for (int m = 0; m < N; m++) if (w < 0 && req[d][m].valid) w = m;
        end else begin
          for (int k = 1; k <= N; k++) begin
            c = (ptr[d] + k) % N;
            if (w < 0 && req[d][c].valid) w = c;
          end
        end
        if (w >= 0) begin
          owner[d] = w;
          ptr[d]   = w;
          beats[d] = int'(req[d][w].len) + 1;
          if (d == 0) exp_q0.push_back(2'(w));
          else        exp_q1.push_back(2'(w));
        end
      end
      for (int m = 0; m < N; m++) begin
        if (m != fin && !req[d][m].valid && $urandom_range(99) < new_pct)
          nreq[d][m] = new_req();
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int d = 0; d < D; d++) begin
        for (int m = 0; m < N; m++) req[d][m] = nreq[d][m];
        drive_mem(d);
      end
      #1;
      for (int d = 0; d < D; d++) begin
        check_outputs(d);
        advance(d);
      end
    end
  endtask

  // An owner must keep valid asserted until its final beat.
  always @(posedge clk) begin
    for (int d = 0; d < D; d++) begin
      if (reset_ && busy_o[d])
        assert (req[d][index_o[d]].valid) else $error("owner %0d dropped valid mid-burst", d);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gmin, gmax, t;
    reset_    = 1'b0;
    rdy_pct   = 100;
    new_pct   = 0;
    rereq_pct = 0;
    model_reset();
    for (int d = 0; d < D; d++) begin
      for (int m = 0; m < N; m++) begin
        req[d][m]   = '0;
        g_cnt[d][m] = 0;
      end
      oresp[d] = '0;
    end

    run_cycles(3);
    for (int d = 0; d < D; d++)
      check($sformatf("rst_index[%0d]", d), 128'(index_o[d]), 128'(0));
    @(posedge clk);
    #2 reset_ = 1'b1;

    // Every master requests continuously with no memory stalls.
    new_pct   = 100;
    rereq_pct = 100;
    rdy_pct   = 100;
    run_cycles(120);
    gmin = g_cnt[0][0];
    gmax = g_cnt[0][0];
    for (int m = 1; m < N; m++) begin
      if (g_cnt[0][m] < gmin) gmin = g_cnt[0][m];
      if (g_cnt[0][m] > gmax) gmax = g_cnt[0][m];
    end
    check("rr_fairness", 128'(gmax - gmin <= 1), 128'(1));
    check("rr_all_served", 128'(gmin > 0), 128'(1));
    check("fp_port0_wins", 128'(g_cnt[1][1] + g_cnt[1][2]), 128'(0));
    check("fp_port0_served", 128'(g_cnt[1][0] > 0), 128'(1));

    // Random traffic, then heavy memory stalls.
    new_pct   = 30;
    rereq_pct = 40;
    rdy_pct   = 60;
    run_cycles(400);
    rdy_pct = 25;
    run_cycles(200);

    // Asynchronous reset in the middle of bursts on both instances.
    new_pct   = 60;
    rereq_pct = 60;
    t = 0;
    while (!(owner[0] >= 0 && owner[1] >= 0) && t < 300) begin
      run_cycles(1);
      t++;
    end
    check("rst_setup_busy", 128'(owner[0] >= 0 && owner[1] >= 0), 128'(1));
    @(posedge clk);
    #2 reset_ = 1'b0;
    #1;
    for (int d = 0; d < D; d++) begin
      check($sformatf("async_rst_oreq[%0d]", d), 128'(oreq[d]), 128'(0));
      check($sformatf("async_rst_busy[%0d]", d), 128'(busy_o[d]), 128'(0));
      for (int m = 0; m < N; m++)
        check($sformatf("async_rst_iresps[%0d][%0d]", d, m), 128'(iresp[d][m]), 128'(0));
    end
    model_reset();
    for (int d = 0; d < D; d++)
      for (int m = 0; m < N; m++) req[d][m] = '0;
    new_pct   = 0;
    rereq_pct = 0;
    rdy_pct   = 50;
    @(posedge clk);
    #2 reset_ = 1'b1;
    for (int d = 0; d < D; d++) nreq[d][1] = new_req();
    run_cycles(2);
    for (int d = 0; d < D; d++) begin
      check($sformatf("post_rst_busy[%0d]", d), 128'(busy_o[d]), 128'(1));
      check($sformatf("post_rst_index[%0d]", d), 128'(index_o[d]), 128'(1));
    end

    new_pct   = 40;
    rereq_pct = 50;
    rdy_pct   = 70;
    run_cycles(150);
    check("grant_q_drain0", 128'(exp_q0.size() <= 1), 128'(1));
    check("grant_q_drain1", 128'(exp_q1.size() <= 1), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
